// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Stalls EX via busy while iterating and returns result/rd_out on a one-cycle done strobe.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             kill,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [4:0]       rd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RW = WIDTH + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } stateT;

    stateT            state;
    stateT            nextState;
    logic             accept;
    logic [CW-1:0]    count;
    logic [RW-1:0]    remReg;
    logic [WIDTH-1:0] quoReg;
    logic [WIDTH-1:0] divReg;
    logic             negQ;
    logic             negR;
    logic             selRem;

    logic             isSigned;
    logic             aNeg;
    logic             bNeg;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;
    logic             divByZero;
    logic             overflow;
    logic             special;
    logic [WIDTH-1:0] specialResult;
    logic [RW-1:0]    shifted;
    logic [RW:0]      diffExt;
    logic             stepOk;
    logic [RW-1:0]    remNext;
    logic [WIDTH-1:0] quoNext;
    logic [WIDTH-1:0] quoFix;
    logic [WIDTH-1:0] remFix;
    logic [WIDTH-1:0] fixResult;
    logic [1:0]       unusedBits;

    // funct3[2] is implied by the decoder; the final remainder never needs its guard bit
    assign unusedBits = {funct3[2], remReg[RW-1]};

    // State register
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; kill aborts any in-flight operation
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (start && !kill) begin
                    nextState = special ? DONE : CALC;
                end
            end
            CALC: begin
                if (kill) begin
                    nextState = IDLE;
                end else if (count == '0) begin
                    nextState = FIX;
                end
            end
            FIX:     nextState = kill ? IDLE : DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Output decode: busy is a stall request and must react to start in the accept cycle
    always_comb begin
        busy   = 1'b0;
        accept = 1'b0;
        case (state)
            IDLE: begin
                accept = start & ~kill;
                busy   = start & ~kill;
            end
            CALC:    busy = 1'b1;
            FIX:     busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    // Operand conditioning and fast-path detection on the incoming operands
    always_comb begin
        isSigned  = ~funct3[0];
        aNeg      = isSigned & dividend[WIDTH-1];
        bNeg      = isSigned & divisor[WIDTH-1];
        absA      = aNeg ? -dividend : dividend;
        absB      = bNeg ? -divisor : divisor;
        divByZero = (divisor == '0);
        overflow  = isSigned && (dividend == MIN_NEG) && (divisor == '1);
        special   = divByZero | overflow;
        if (divByZero) begin
            specialResult = funct3[1] ? dividend : '1;
        end else begin
            specialResult = funct3[1] ? '0 : MIN_NEG;
        end
    end

    // One restoring step: shift, trial subtract, keep or restore
    always_comb begin
        shifted = {remReg[WIDTH-1:0], quoReg[WIDTH-1]};
        diffExt = {1'b0, shifted} - {2'b00, divReg};
        stepOk  = ~diffExt[RW];
        remNext = stepOk ? diffExt[RW-1:0] : shifted;
        quoNext = {quoReg[WIDTH-2:0], stepOk};
    end

    // Sign correction and quotient/remainder selection
    always_comb begin
        quoFix    = negQ ? -quoReg : quoReg;
        remFix    = negR ? -remReg[WIDTH-1:0] : remReg[WIDTH-1:0];
        fixResult = selRem ? remFix : quoFix;
    end

    // Datapath registers and registered outputs
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count  <= '0;
            remReg <= '0;
            quoReg <= '0;
            divReg <= '0;
            negQ   <= 1'b0;
            negR   <= 1'b0;
            selRem <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            done <= (nextState == DONE);
            if (accept) begin
                selRem <= funct3[1];
                rd_out <= rd;
                negQ   <= (funct3[1:0] == 2'b00) & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                negR   <= (funct3[1:0] == 2'b10) & dividend[WIDTH-1];
                remReg <= '0;
                quoReg <= absA;
                divReg <= absB;
                count  <= CW'(WIDTH - 1);
                if (special) begin
                    result <= specialResult;
                end
            end else if (state == CALC) begin
                remReg <= remNext;
                quoReg <= quoNext;
                if (count != '0) begin
                    count <= count - CW'(1);
                end
            end else if ((state == FIX) && !kill) begin
                result <= fixResult;
            end
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, multi-cycle corner
// sequences (kill, ignored start, reset mid-operation) and a randomized model check.
module tb_div_unit;
    localparam int unsigned W = 32;
    localparam int NORM_LAT = 34;
    localparam int FAST_LAT = 1;

    logic         clk = 1'b0;
    logic         clr;
    logic         start;
    logic         kill;
    logic [2:0]   funct3;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [4:0]   rd;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [4:0]   rd_out;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rdv;
        logic [31:0] exp;
        int          lat;
    } vecT;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .kill     (kill),
        .funct3   (funct3),
        .dividend (dividend),
        .divisor  (divisor),
        .rd       (rd),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .rd_out   (rd_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // RISC-V M-extension semantics computed with plain arithmetic
    function automatic logic [31:0] refModel(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        logic        sgn;
        sgn = ~f3[0];
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (sgn) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
        return f3[1] ? r : q;
    endfunction

    function automatic int refLatency(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        if (b == 32'd0) return FAST_LAT;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return FAST_LAT;
        return NORM_LAT;
    endfunction

    // Called #1 after an edge with start low; returns the cycle offset at which done is seen
    task automatic waitDone(input int maxK, output int k, output int bc,
                            output logic [31:0] res, output logic [4:0] rdo);
        bc  = 0;
        k   = -1;
        res = 'x;
        rdo = 'x;
        for (int i = 0; i < maxK; i++) begin
            if (done) begin
                k   = i;
                res = result;
                rdo = rd_out;
                check("busy_in_done", 32'(busy), 32'(0));
                break;
            end
            bc += int'(busy);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic countDones(input int cycles, output int dc);
        dc = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            dc += int'(done);
        end
    endtask

    task automatic runOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rdv, output logic [31:0] res,
                         output logic [4:0] rdo, output int lat, output int busyCyc);
        int k;
        int bc;
        @(negedge clk);
        funct3   = f3;
        dividend = a;
        divisor  = b;
        rd       = rdv;
        start    = 1'b1;
        #1 busyCyc = int'(busy);
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(60, k, bc, res, rdo);
        lat = (k < 0) ? -1 : k + 1;
        busyCyc += bc;
        @(posedge clk);
        #1 check("done_single_cycle", 32'(done), 32'(0));
    endtask

    task automatic checkOp(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rdv,
                           input logic [31:0] exp, input int expLat);
        logic [31:0] res;
        logic [4:0]  rdo;
        int          lat;
        int          bcyc;
        runOp(f3, a, b, rdv, res, rdo, lat, bcyc);
        check({tag, "_result"}, res, exp);
        check({tag, "_rd"}, 32'(rdo), 32'(rdv));
        check({tag, "_latency"}, 32'(lat), 32'(expLat));
        check({tag, "_busy"}, 32'(bcyc), 32'(expLat));
    endtask

    initial begin
        vecT         vecs[$];
        logic [31:0] res;
        logic [4:0]  rdo;
        logic [31:0] prevRes;
        int          k;
        int          bc;
        int          dc;

        clr      = 1'b0;
        start    = 1'b0;
        kill     = 1'b0;
        funct3   = 3'b000;
        dividend = '0;
        divisor  = '0;
        rd       = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_done", 32'(done), 32'(0));
        check("reset_result", result, 32'h0);
        check("reset_rd_out", 32'(rd_out), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        @(negedge clk) clr = 1'b1;

        vecs.push_back('{F_DIVU, 32'd100,        32'd7,        5'd5,  32'd14,        NORM_LAT});
        vecs.push_back('{F_REMU, 32'd100,        32'd7,        5'd6,  32'd2,         NORM_LAT});
        vecs.push_back('{F_DIV,  32'hFFFF_FFF9,  32'd2,        5'd7,  32'hFFFF_FFFD, NORM_LAT});
        vecs.push_back('{F_REM,  32'hFFFF_FFF9,  32'd2,        5'd8,  32'hFFFF_FFFF, NORM_LAT});
        vecs.push_back('{F_DIV,  32'd7,          32'hFFFF_FFFE, 5'd9,  32'hFFFF_FFFD, NORM_LAT});
        vecs.push_back('{F_REM,  32'd7,          32'hFFFF_FFFE, 5'd10, 32'd1,         NORM_LAT});
        vecs.push_back('{F_DIV,  32'h8000_0000,  32'd2,        5'd11, 32'hC000_0000, NORM_LAT});
        vecs.push_back('{F_DIVU, 32'd5,          32'd0,        5'd12, 32'hFFFF_FFFF, FAST_LAT});
        vecs.push_back('{F_REMU, 32'd5,          32'd0,        5'd13, 32'd5,         FAST_LAT});
        vecs.push_back('{F_DIV,  32'hFFFF_FFFB,  32'd0,        5'd14, 32'hFFFF_FFFF, FAST_LAT});
        vecs.push_back('{F_REM,  32'hFFFF_FFFB,  32'd0,        5'd15, 32'hFFFF_FFFB, FAST_LAT});
        vecs.push_back('{F_DIV,  32'h8000_0000,  32'hFFFF_FFFF, 5'd16, 32'h8000_0000, FAST_LAT});
        vecs.push_back('{F_REM,  32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'd0,         FAST_LAT});
        vecs.push_back('{F_DIVU, 32'hFFFF_FFFF,  32'd1,        5'd18, 32'hFFFF_FFFF, NORM_LAT});
        vecs.push_back('{F_DIVU, 32'h8000_0000,  32'hFFFF_FFFF, 5'd19, 32'd0,         NORM_LAT});
        vecs.push_back('{F_REMU, 32'h8000_0000,  32'hFFFF_FFFF, 5'd31, 32'h8000_0000, NORM_LAT});

        foreach (vecs[i]) begin
            checkOp($sformatf("vec%0d", i), vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rdv,
                    vecs[i].exp, vecs[i].lat);
        end

        // Kill on the 10th CALC cycle: no strobe, result untouched
        prevRes = result;
        @(negedge clk);
        funct3 = F_DIVU; dividend = 32'd1000; divisor = 32'd3; rd = 5'd20; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        check("kill_busy_low", 32'(busy), 32'(0));
        check("kill_no_done", 32'(done), 32'(0));
        countDones(40, dc);
        check("kill_no_late_done", 32'(dc), 32'(0));
        check("kill_result_hold", result, prevRes);

        // kill overrides start in IDLE
        @(negedge clk);
        funct3 = F_DIVU; dividend = 32'd8; divisor = 32'd2; rd = 5'd21; start = 1'b1; kill = 1'b1;
        #1 check("kill_over_start_busy", 32'(busy), 32'(0));
        @(posedge clk);
        #1 begin start = 1'b0; kill = 1'b0; end
        countDones(40, dc);
        check("kill_over_start_no_done", 32'(dc), 32'(0));
        checkOp("after_kill", F_DIVU, 32'd9, 32'd3, 5'd22, 32'd3, NORM_LAT);

        // start pulsed mid-CALC is ignored and does not queue
        @(negedge clk);
        funct3 = F_DIVU; dividend = 32'd100; divisor = 32'd7; rd = 5'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        funct3 = F_DIV; dividend = 32'd50; divisor = 32'd5; rd = 5'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(60, k, bc, res, rdo);
        check("midcalc_result", res, 32'd14);
        check("midcalc_rd", 32'(rdo), 32'(5));
        check("midcalc_latency", 32'((k < 0) ? -1 : k + 7), 32'(NORM_LAT));
        countDones(40, dc);
        check("midcalc_no_queue", 32'(dc), 32'(0));

        // start during DONE is ignored, then accepted in the following IDLE cycle
        @(negedge clk);
        funct3 = F_DIVU; dividend = 32'd9; divisor = 32'd3; rd = 5'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(60, k, bc, res, rdo);
        check("b2b_first_result", res, 32'd3);
        funct3 = F_REMU; dividend = 32'd20; divisor = 32'd6; rd = 5'd4; start = 1'b1;
        #1 check("start_in_done_busy", 32'(busy), 32'(0));
        @(posedge clk);
        #1;
        check("idle_after_done", 32'(done), 32'(0));
        check("idle_start_busy", 32'(busy), 32'(1));
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(60, k, bc, res, rdo);
        check("b2b_second_result", res, 32'd2);
        check("b2b_second_rd", 32'(rdo), 32'(4));
        check("b2b_second_latency", 32'((k < 0) ? -1 : k + 1), 32'(NORM_LAT));

        // Asynchronous reset between edges mid-CALC
        @(negedge clk);
        funct3 = F_DIVU; dividend = 32'd1000; divisor = 32'd7; rd = 5'd12; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #3 clr = 1'b0;
        #1;
        check("areset_result", result, 32'h0);
        check("areset_rd_out", 32'(rd_out), 32'(0));
        check("areset_done", 32'(done), 32'(0));
        check("areset_busy", 32'(busy), 32'(0));
        @(posedge clk);
        @(negedge clk) clr = 1'b1;
        countDones(40, dc);
        check("areset_no_done", 32'(dc), 32'(0));
        checkOp("after_reset", F_REMU, 32'd10, 32'd4, 5'd13, 32'd2, NORM_LAT);

        // Randomized operations against the arithmetic reference
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f3;
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  rv;
            int          sel;
            f3  = 3'b100 | 3'($urandom_range(0, 3));
            a   = $urandom;
            b   = $urandom;
            rv  = 5'($urandom);
            sel = $urandom_range(0, 15);
            if (sel < 2) b = 32'd0;
            else if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel < 6) b = 32'($urandom_range(1, 20));
            else if (sel == 6) b = -32'($urandom_range(1, 20));
            checkOp($sformatf("rnd%0d", i), f3, a, b, rv, refModel(f3, a, b),
                    refLatency(f3, a, b));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
